// File: rtl/axi_hbm_rd_dma_if.sv
// Bus bundle for the HBM read DMA: descriptor input, AXI AR/R master, AXI-stream out.
// master: DMA side (drives desc_ready, AR request, rready, stream out).
// slave : environment side (drives descriptor, arready, R beats, tready).
interface axi_hbm_rd_dma_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] desc_addr;
  logic [LEN_WIDTH-1:0]  desc_len;
  logic                  desc_valid;
  logic                  desc_ready;

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport master (
    input  desc_addr, desc_len, desc_valid,
    output desc_ready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    output desc_addr, desc_len, desc_valid,
    input  desc_ready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_hbm_rd_dma.sv
// Read-DMA master: splits a (start address, beat count) descriptor into INCR AR
// bursts (never crossing 4 KB) and streams R data out with tlast on the final beat.
// Ports: clk, rst_n (async active-low); bus (axi_hbm_rd_dma_if.master: descriptor,
// AXI AR/R, AXI-stream); done (1-cycle completion pulse); err (sticky rresp error);
// stat_beats / stat_stalls (saturating counters, built only with HBM_RD_DMA_STATS_EN).
module axi_hbm_rd_dma #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned ARID_VAL        = 0,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_BURST_LEN   = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_hbm_rd_dma_if.master       bus,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_stalls
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SZ    = $clog2(BYTES);
  localparam int unsigned CW    = LEN_WIDTH + 1;
  localparam int unsigned OW    = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         rem_q, total_q, rcv_q;
  logic [OW-1:0]         outst_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  desc_ready_q, done_q, err_q;

  logic        active, desc_hs, ar_hs, ar_load, r_hs, rlast_hs, last_beat;
  logic [31:0] page_beats, burst_beats;

  assign active    = (state_q != IDLE);
  assign desc_hs   = bus.desc_valid & desc_ready_q;
  assign ar_hs     = arvalid_q & bus.m_axi_arready;
  assign r_hs      = bus.m_axi_rvalid & bus.m_axi_rready;
  assign rlast_hs  = r_hs & bus.m_axi_rlast;
  assign last_beat = (rcv_q == total_q - CW'(1));
  assign ar_load   = (state_q == ISSUE) & ~arvalid_q & (rem_q != '0) &
                     (outst_q < OW'(MAX_OUTSTANDING));

  assign bus.desc_ready    = desc_ready_q;
  assign bus.m_axi_arid    = ID_WIDTH'(ARID_VAL);
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.m_axi_arsize  = 3'(SZ);
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = arvalid_q;

  // Zero-latency R -> stream pass-through, closed off while idle
  assign bus.m_axis_tvalid = bus.m_axi_rvalid & active;
  assign bus.m_axis_tdata  = bus.m_axi_rdata;
  assign bus.m_axis_tlast  = last_beat;
  assign bus.m_axi_rready  = bus.m_axis_tready & active;

  assign done = done_q;
  assign err  = err_q;

  // Next burst size: limited by remaining beats, max burst and the 4 KB page end
  always_comb begin
    page_beats  = 32'((13'h1000 - {1'b0, addr_q[11:0]}) >> SZ);
    burst_beats = 32'(rem_q);
    if (burst_beats > 32'(MAX_BURST_LEN)) burst_beats = 32'(MAX_BURST_LEN);
    if (burst_beats > page_beats)         burst_beats = page_beats;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (desc_hs) state_d = ISSUE;
      ISSUE:   if (ar_hs && (rem_q == CW'(arlen_q) + CW'(1))) state_d = DRAIN;
      DRAIN:   if (rcv_q == total_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, descriptor bookkeeping and AR request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      desc_ready_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
      total_q      <= '0;
      rcv_q        <= '0;
      outst_q      <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
    end else begin
      state_q      <= state_d;
      desc_ready_q <= (state_d == IDLE);
      done_q       <= r_hs & last_beat;
      if (desc_hs) begin
        addr_q  <= bus.desc_addr & ~ADDR_WIDTH'(BYTES - 1);
        rem_q   <= CW'(bus.desc_len) + CW'(1);
        total_q <= CW'(bus.desc_len) + CW'(1);
        rcv_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        if (r_hs) begin
          rcv_q <= rcv_q + CW'(1);
          if (bus.m_axi_rresp != 2'b00) err_q <= 1'b1;
        end
        if (ar_load) begin
          arvalid_q <= 1'b1;
          araddr_q  <= addr_q;
          arlen_q   <= 8'(burst_beats - 32'd1);
        end else if (ar_hs) begin
          arvalid_q <= 1'b0;
          addr_q    <= addr_q + ADDR_WIDTH'((32'(arlen_q) + 32'd1) << SZ);
          rem_q     <= rem_q - (CW'(arlen_q) + CW'(1));
        end
      end
      // Simultaneous issue and burst completion leave the count unchanged
      case ({ar_hs, rlast_hs})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

`ifdef HBM_RD_DMA_STATS_EN
  logic [31:0] beats_q, stalls_q;

  // Saturating beat / stall counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (r_hs && (beats_q != 32'hFFFF_FFFF)) beats_q <= beats_q + 32'd1;
      if (bus.m_axis_tvalid && !bus.m_axis_tready && (stalls_q != 32'hFFFF_FFFF))
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_axi_hbm_rd_dma.sv
// Self-checking bench for axi_hbm_rd_dma: descriptor driver, AXI read slave model
// and scoreboard of expected AR requests and stream beats.
module tb_axi_hbm_rd_dma;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned MAXB = 16;
  localparam int unsigned MAXO = 2;

  typedef struct { logic [15:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done, err;
  logic [31:0] stat_beats, stat_stalls;

  axi_hbm_rd_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

  axi_hbm_rd_dma #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .ARID_VAL(0), .LEN_WIDTH(LW),
    .MAX_BURST_LEN(MAXB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .done(done), .err(err),
    .stat_beats(stat_beats), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  ar_t   exp_ar_q[$];
  beat_t exp_beat_q[$];
  ar_t   burst_q[$];

  logic        desc_pend = 1'b0;
  logic [15:0] pend_addr = '0;
  logic [15:0] pend_len = '0;
  logic        bp_en = 1'b0, err_inj = 1'b0;
  logic        desc_hs, done_now;
  logic        r_active = 1'b0;
  logic [15:0] r_addr;
  int          r_len, r_cnt, rbeat, outst, cyc, last_cyc, beat_tot, stall_tot;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'h5AC3, a};
  endfunction

  task automatic chk_stats();
`ifdef HBM_RD_DMA_STATS_EN
    chk("stat_beats", 64'(stat_beats), 64'(beat_tot));
    chk("stat_stalls", 64'(stat_stalls), 64'(stall_tot));
`else
    chk("stat_beats", 64'(stat_beats), 64'd0);
    chk("stat_stalls", 64'(stat_stalls), 64'd0);
`endif
  endtask

  // One clock: drive at negedge, settle, then score what the next posedge will take
  task automatic tick();
    @(negedge clk);
    bus.desc_valid    = desc_pend;
    bus.desc_addr     = pend_addr;
    bus.desc_len      = pend_len;
    bus.m_axi_arready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!r_active && burst_q.size() > 0) begin
      ar_t b;
      b = burst_q.pop_front();
      r_addr = b.addr; r_len = int'(b.len); r_cnt = 0; r_active = 1'b1;
    end
    bus.m_axi_rvalid = r_active;
    bus.m_axi_rdata  = pat(r_addr);
    bus.m_axi_rlast  = r_active && (r_cnt == r_len);
    bus.m_axi_rresp  = (r_active && err_inj && rbeat == 2) ? 2'b10 : 2'b00;
    #1;
    cyc++;
    desc_hs  = bus.desc_valid && bus.desc_ready;
    done_now = done;
    if (bus.m_axi_arvalid && bus.m_axi_arready) begin
      if (exp_ar_q.size() == 0) chk("ar_extra", 64'(exp_ar_q.size()), 64'd1);
      else begin
        ar_t e;
        e = exp_ar_q.pop_front();
        chk("araddr", 64'(bus.m_axi_araddr), 64'(e.addr));
        chk("arlen", 64'(bus.m_axi_arlen), 64'(e.len));
        chk("arid", 64'(bus.m_axi_arid), 64'd0);
        chk("arsize", 64'(bus.m_axi_arsize), 64'd2);
        chk("arburst", 64'(bus.m_axi_arburst), 64'd1);
      end
      burst_q.push_back('{bus.m_axi_araddr, bus.m_axi_arlen});
      outst++;
      chk("outst_max", 64'(outst <= int'(MAXO)), 64'd1);
    end
    if (bus.m_axi_rvalid && bus.m_axi_rready) begin
      beat_tot++;
      rbeat++;
      if (exp_beat_q.size() == 0) chk("beat_extra", 64'(exp_beat_q.size()), 64'd1);
      else begin
        beat_t e;
        e = exp_beat_q.pop_front();
        chk("tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("tdata", 64'(bus.m_axis_tdata), 64'(e.data));
        chk("tlast", 64'(bus.m_axis_tlast), 64'(e.last));
        if (e.last) last_cyc = cyc;
      end
      if (r_cnt == r_len) begin r_active = 1'b0; outst--; end
      else begin r_cnt++; r_addr = r_addr + 16'd4; end
    end
    if (bus.m_axi_rvalid && !bus.m_axis_tready) stall_tot++;
  endtask

  // Build expectations, present the descriptor and wait for acceptance
  task automatic start_desc(input logic [15:0] addr, input int len, input logic inj,
                            input logic bp);
    logic [15:0] a;
    int rem, b, pg;
    logic acc;
    err_inj = inj; bp_en = bp; rbeat = 0;
    a = addr & 16'hFFFC;
    rem = len + 1;
    while (rem > 0) begin
      b = rem;
      if (b > int'(MAXB)) b = int'(MAXB);
      pg = (4096 - int'(a[11:0])) / 4;
      if (b > pg) b = pg;
      exp_ar_q.push_back('{a, 8'(b - 1)});
      a = a + 16'(b * 4);
      rem -= b;
    end
    a = addr & 16'hFFFC;
    for (int i = 0; i <= len; i++) exp_beat_q.push_back('{pat(a + 16'(i * 4)), i == len});
    pend_addr = addr; pend_len = 16'(len); desc_pend = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin tick(); acc = desc_hs; end
    desc_pend = 1'b0;
    chk("desc_acc", 64'(acc), 64'd1);
    tick();
    chk("err_clr", 64'(err), 64'd0);
  endtask

  // Wait for completion and check the tail of the transfer
  task automatic finish_desc(input logic exp_err);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin tick(); got = done_now; end
    chk("done_seen", 64'(got), 64'd1);
    chk("done_lat", 64'(cyc - last_cyc), 64'd1);
    chk("ar_left", 64'(exp_ar_q.size()), 64'd0);
    chk("beat_left", 64'(exp_beat_q.size()), 64'd0);
    chk("err", 64'(err), 64'(exp_err));
    chk_stats();
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    chk("desc_rdy", 64'(bus.desc_ready), 64'd1);
    chk("err_hold", 64'(err), 64'(exp_err));
  endtask

  initial begin
    logic ok;
    cyc = 0; last_cyc = 0; outst = 0; beat_tot = 0; stall_tot = 0; rbeat = 0;
    r_len = 0; r_cnt = 0; r_addr = '0;
    bus.desc_valid = 1'b0; bus.desc_addr = '0; bus.desc_len = '0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_desc_rdy", 64'(bus.desc_ready), 64'd0);
    chk("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_stats();
    rst_n = 1'b1;
    tick();
    chk("rdy_first", 64'(bus.desc_ready), 64'd1);

    start_desc(16'h0100, 7, 1'b0, 1'b0);  finish_desc(1'b0);   // single burst
    start_desc(16'h0000, 39, 1'b0, 1'b0); finish_desc(1'b0);   // 16/16/8 split
    start_desc(16'h0FF8, 5, 1'b0, 1'b0);  finish_desc(1'b0);   // 4 KB crossing
    start_desc(16'h0102, 0, 1'b0, 1'b0);  finish_desc(1'b0);   // single beat, unaligned
    start_desc(16'hFFF0, 7, 1'b0, 1'b0);  finish_desc(1'b0);   // address wrap
    start_desc(16'h0200, 63, 1'b0, 1'b1); finish_desc(1'b0);   // backpressure
    start_desc(16'h0300, 7, 1'b1, 1'b0);  finish_desc(1'b1);   // rresp error on beat 3
    start_desc(16'h0340, 3, 1'b0, 1'b0);  finish_desc(1'b0);   // err cleared on accept

    // Reset in the middle of DRAIN
    start_desc(16'h0400, 63, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin tick(); ok = (exp_ar_q.size() == 0); end
    chk("all_ar_issued", 64'(ok), 64'd1);
    tick();
    chk("beats_pending", 64'(exp_beat_q.size() > 0), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
    chk("mid_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_rdy", 64'(bus.desc_ready), 64'd0);
    exp_ar_q.delete(); exp_beat_q.delete(); burst_q.delete();
    r_active = 1'b0; outst = 0; beat_tot = 0; stall_tot = 0; bp_en = 1'b0;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", 64'(bus.desc_ready), 64'd1);
    chk_stats();
    start_desc(16'h0500, 9, 1'b0, 1'b0); finish_desc(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/axi_hbm_rd_dma.md
Name: axi_hbm_rd_dma

Overview:
Read-DMA master that sits directly upstream of the HBM AXI slave model. It accepts a descriptor (start address, beat count) and splits it into INCR read bursts on the AR channel. It streams the returned R data out as an AXI-stream with tlast on the final beat. It is used by top-level sim and datapath blocks to pull contiguous buffers out of HBM.

Parameters:
DATA_WIDTH, 32, AXI/stream data width in bits (power of two, >= 8)
ADDR_WIDTH, 16, AXI address width in bits
ID_WIDTH, 8, AXI ID width; all ARs use the constant ID in ARID_VAL
ARID_VAL, 0, ARID driven on every request
LEN_WIDTH, 16, descriptor beat-count width
MAX_BURST_LEN, 16, maximum beats per AR burst (1..256)
MAX_OUTSTANDING, 4, maximum ARs issued whose last R beat has not yet returned (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
desc_addr  in  ADDR_WIDTH  start byte address; bits below log2(DATA_WIDTH/8) are ignored (treated as 0)
desc_len  in  LEN_WIDTH  number of beats minus 1
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accepted when desc_valid && desc_ready
m_axi_arid  out  ID_WIDTH  = ARID_VAL
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen  out  8  burst beats minus 1
m_axi_arsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of a burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tlast  out  1  final beat of the descriptor
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
done  out  1  one-cycle pulse when the descriptor has fully completed
err  out  1  sticky flag: some R beat had rresp != 0; cleared when the next descriptor is accepted
stat_beats  out  32  beat counter (feature-dependent)
stat_stalls  out  32  stall counter (feature-dependent)

Behaviour:
- Reset (asynchronous, rst_n=0) sets all outputs and state to 0:
  - desc_ready=0, arvalid=0, tvalid=0, done=0, err=0, counters=0.
  - State returns to IDLE at once; any in-flight transfer is abandoned.
  - desc_ready rises on the first clock edge after rst_n deasserts.
- States:
  - IDLE: desc_ready=1. On a descriptor handshake, latch addr, remaining=desc_len+1 and total=desc_len+1; clear err; go to ISSUE. desc_ready is 0 outside IDLE.
  - ISSUE: drive ARs while remaining>0 and outstanding<MAX_OUTSTANDING.
    - Burst beats = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) >> log2(DATA_WIDTH/8)); bursts never cross a 4 KB boundary.
    - arvalid, araddr and arlen are registered and held stable until arready.
    - On the AR handshake: addr += beats*bytes, remaining -= beats, outstanding++.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait for the R beats. When received==total, pulse done for 1 cycle, then return to IDLE.
- R path is combinational pass-through, zero latency:
  - tvalid=rvalid, tdata=rdata, rready=tready.
  - R may be accepted in both ISSUE and DRAIN; rready=0 in IDLE.
- Outstanding count:
  - Decrements on a beat with rvalid && rready && rlast.
  - AR issue and rlast in the same cycle leave the count unchanged.
- tlast=1 on the beat where received==total-1, regardless of rlast.
- Any accepted beat with rresp!=0 sets err; the data is still forwarded.
- Address wraps modulo 2^ADDR_WIDTH.
- Worked example, desc_len=0: one AR with arlen=0, one beat with tlast=1, done one cycle after that beat.

Optional Feature:
- Macro: HBM_RD_DMA_STATS_EN.
- Defined:
  - stat_beats counts every accepted R beat.
  - stat_stalls counts cycles with tvalid && !tready.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared only by reset.
- Undefined: stat_beats and stat_stalls are tied to 0 and no counter logic is built.

Test Plan:
- Small read, DATA_WIDTH=32: addr=0x0100, desc_len=7, tready=1 -> one AR (araddr=0x0100, arlen=7); 8 beats streamed; tlast on beat 8; done one cycle later; err=0.
- Burst splitting: addr=0x0000, desc_len=39, MAX_BURST_LEN=16 -> ARs arlen=15/15/7 at 0x0000/0x0040/0x0080; 40 beats; a single tlast.
- 4 KB boundary: addr=0x0FF8, desc_len=5 -> ARs (0x0FF8, arlen=1) then (0x1000, arlen=3).
- Backpressure plus outstanding limit: MAX_OUTSTANDING=2, desc_len=63, tready toggling 50% -> never more than 2 ARs unacknowledged; all 64 beats in order; with the macro defined, stat_beats=64 and stat_stalls equals the stall cycles.
- Error and reset: rresp=2'b10 on beat 3 -> err=1 until the next descriptor is accepted. Assert rst_n=0 mid-DRAIN -> arvalid, tvalid and done are 0 immediately; after release, desc_ready=1 and a new descriptor completes correctly.
